// File: rtl/idelay_tap_cal.sv
// IDELAY tap calibration: sweeps a shared tap across all lanes, scores each tap against
// a training pattern, loads the centre of the longest passing window and verifies readback.
module idelay_tap_cal #(
   parameter int unsigned      WIDTH         = 1,
   parameter int unsigned      MAX_TAP       = 511,
   parameter int unsigned      TAP_STEP      = 8,
   parameter int unsigned      VTC_WAIT      = 16,
   parameter int unsigned      SETTLE_CYCLES = 16,
   parameter int unsigned      SAMPLE_CYCLES = 64,
   parameter logic [WIDTH-1:0] EXP_Q1        = '1,
   parameter logic [WIDTH-1:0] EXP_Q2        = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   q1,
   input  logic [WIDTH-1:0]   q2,
   input  logic [WIDTH*9-1:0] cnt_value_out,
   output logic               load,
   output logic [8:0]         cnt_value_in,
   output logic               en_vtc,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [8:0]         final_tap,
   output logic [9:0]         eye_width
);

   typedef enum logic [3:0] {
      S_IDLE, S_VTC_OFF, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL,
      S_CHOOSE, S_FINAL_LOAD, S_FINAL_SETTLE, S_CHECK, S_DONE
   } state_t;

   state_t      state, state_d;
   logic [15:0] cnt, cnt_d;
   logic [9:0]  tap, tap_d;
   logic        pass_ok, pass_d;
   logic [9:0]  run_start, run_start_d, run_len, run_len_d;
   logic [9:0]  best_start, best_start_d, best_len, best_len_d;
   logic        load_d, en_vtc_d, busy_d, done_d, error_d;
   logic [8:0]  cnt_value_in_d, final_tap_d;
   logic [9:0]  eye_width_d;
   logic [10:0] tap_sum;
   logic [8:0]  centre;
   logic        rb_mismatch;

   assign tap_sum = {1'b0, tap} + 11'(TAP_STEP);
   assign centre  = 9'(32'(best_start) + (((32'(best_len) - 32'd1) * 32'(TAP_STEP)) >> 1));

   always_comb begin
      rb_mismatch = 1'b0;
      for (int unsigned n = 0; n < WIDTH; n++)
         if (cnt_value_out[n*9 +: 9] != final_tap) rb_mismatch = 1'b1;
   end

   always_comb begin
      state_d        = state;
      cnt_d          = cnt + 16'd1;
      tap_d          = tap;
      pass_d         = pass_ok;
      run_start_d    = run_start;
      run_len_d      = run_len;
      best_start_d   = best_start;
      best_len_d     = best_len;
      load_d         = 1'b0;
      cnt_value_in_d = cnt_value_in;
      en_vtc_d       = en_vtc;
      busy_d         = busy;
      done_d         = done;
      error_d        = error;
      final_tap_d    = final_tap;
      eye_width_d    = eye_width;
      case (state)
         S_IDLE, S_DONE: begin
            cnt_d = '0;
            if (start) begin
               state_d      = S_VTC_OFF;
               done_d       = 1'b0;
               error_d      = 1'b0;
               busy_d       = 1'b1;
               en_vtc_d     = 1'b0;
               run_len_d    = '0;
               run_start_d  = '0;
               best_len_d   = '0;
               best_start_d = '0;
            end
         end
         S_VTC_OFF: begin
            tap_d = '0;
            if (cnt == 16'(VTC_WAIT - 1)) begin
               state_d        = S_LOAD;
               load_d         = 1'b1;
               cnt_value_in_d = '0;
            end
         end
         S_LOAD: state_d = S_SETTLE;
         S_SETTLE: begin
            if (cnt == 16'(SETTLE_CYCLES - 1)) begin
               state_d = S_SAMPLE;
               pass_d  = 1'b1;
            end
         end
         S_SAMPLE: begin
            if (q1 != EXP_Q1 || q2 != EXP_Q2) pass_d = 1'b0;
            if (cnt == 16'(SAMPLE_CYCLES - 1)) state_d = S_EVAL;
         end
         S_EVAL: begin
            if (pass_ok) begin
               if (run_len == '0) run_start_d = tap;
               run_len_d = run_len + 10'd1;
            end else begin
               if (run_len > best_len) begin
                  best_len_d   = run_len;
                  best_start_d = run_start;
               end
               run_len_d = '0;
            end
            // A run still open at the end of the sweep competes with the updated best
            if (tap_sum <= 11'(MAX_TAP)) begin
               tap_d          = tap_sum[9:0];
               load_d         = 1'b1;
               cnt_value_in_d = tap_sum[8:0];
               state_d        = S_LOAD;
            end else begin
               if (run_len_d > best_len_d) begin
                  best_len_d   = run_len_d;
                  best_start_d = run_start_d;
               end
               run_len_d = '0;
               state_d   = S_CHOOSE;
            end
         end
         S_CHOOSE: begin
            if (best_len == '0) begin
               final_tap_d = '0;
               eye_width_d = '0;
               error_d     = 1'b1;
            end else begin
               final_tap_d = centre;
               eye_width_d = best_len;
            end
            load_d         = 1'b1;
            cnt_value_in_d = final_tap_d;
            state_d        = S_FINAL_LOAD;
         end
         S_FINAL_LOAD: state_d = S_FINAL_SETTLE;
         S_FINAL_SETTLE: begin
            if (cnt == 16'(SETTLE_CYCLES - 1)) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (rb_mismatch) error_d = 1'b1;
            en_vtc_d = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d != state) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cnt          <= '0;
         tap          <= '0;
         pass_ok      <= 1'b0;
         run_start    <= '0;
         run_len      <= '0;
         best_start   <= '0;
         best_len     <= '0;
         load         <= 1'b0;
         cnt_value_in <= '0;
         en_vtc       <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         final_tap    <= '0;
         eye_width    <= '0;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         tap          <= tap_d;
         pass_ok      <= pass_d;
         run_start    <= run_start_d;
         run_len      <= run_len_d;
         best_start   <= best_start_d;
         best_len     <= best_len_d;
         load         <= load_d;
         cnt_value_in <= cnt_value_in_d;
         en_vtc       <= en_vtc_d;
         busy         <= busy_d;
         done         <= done_d;
         error        <= error_d;
         final_tap    <= final_tap_d;
         eye_width    <= eye_width_d;
      end
   end

endmodule

// File: tb/tb_idelay_tap_cal.sv
// Bench for idelay_tap_cal: behavioural IDELAY/IDDR stand-in driven by a per-tap pass mask,
// results compared against a window-search reference model.
module tb_idelay_tap_cal;

   localparam int WIDTH  = 2;
   localparam int STEP   = 64;
   localparam int SETTLE = 4;
   localparam int SAMPLE = 8;
   localparam int VTC    = 16;
   localparam int NPTS   = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [WIDTH-1:0]   q1, q2;
   logic [WIDTH*9-1:0] cnt_value_out;
   logic               load, en_vtc, busy, done, error;
   logic [8:0]         cnt_value_in, final_tap;
   logic [9:0]         eye_width;

   int checks = 0;
   int failures = 0;

   logic [8:0] cur_tap = '0;
   int         since_load = 0;
   int         load_cnt = 0;
   logic       load_prev = 1'b0;
   logic       dbl_load = 1'b0;
   logic [7:0] pass_mask = '0;
   logic       glitch_en = 1'b0;
   logic       corrupt = 1'b0;
   logic [3:0] bad = 4'h1;

   idelay_tap_cal #(
      .WIDTH(WIDTH), .MAX_TAP(511), .TAP_STEP(STEP), .VTC_WAIT(VTC),
      .SETTLE_CYCLES(SETTLE), .SAMPLE_CYCLES(SAMPLE),
      .EXP_Q1(2'b11), .EXP_Q2(2'b00)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .q1(q1), .q2(q2),
      .cnt_value_out(cnt_value_out), .load(load), .cnt_value_in(cnt_value_in),
      .en_vtc(en_vtc), .busy(busy), .done(done), .error(error),
      .final_tap(final_tap), .eye_width(eye_width)
   );

   always #5 clk = ~clk;

   // Delay line stand-in: latches the tap on load, returns it on every lane
   always @(posedge clk) begin
      if (load) begin
         cur_tap    <= cnt_value_in;
         since_load <= 0;
         load_cnt   <= load_cnt + 1;
      end else if (since_load < 1000) begin
         since_load <= since_load + 1;
      end
      if (load && load_prev) dbl_load <= 1'b1;
      load_prev <= load;
   end

   assign cnt_value_out = {cur_tap, cur_tap ^ (corrupt ? 9'h001 : 9'h000)};

   always_comb begin
      if (pass_mask[cur_tap[8:6]]) begin
         q1 = 2'b11;
         q2 = 2'b00;
      end else begin
         q1 = 2'b11 ^ bad[1:0];
         q2 = bad[3:2];
      end
      if (glitch_en && cur_tap == 9'd192 && since_load == 7) q1[1] = ~q1[1];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Longest run of passing sweep points; strictly-longer wins so ties keep the lowest tap
   function automatic void ref_model(input logic [7:0] m, output int fin, output int wid);
      int bs = 0, bl = 0, rs = 0, rl = 0;
      for (int i = 0; i <= NPTS; i++) begin
         if (i < NPTS && m[i]) begin
            if (rl == 0) rs = i;
            rl++;
         end else begin
            if (rl > bl) begin
               bl = rl;
               bs = rs;
            end
            rl = 0;
         end
      end
      wid = bl;
      fin = (bl == 0) ? 0 : bs * STEP + ((bl - 1) * STEP) / 2;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_load"}, 32'(load), 0);
      chk({tag, "_cvi"}, 32'(cnt_value_in), 0);
      chk({tag, "_en_vtc"}, 32'(en_vtc), 1);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_error"}, 32'(error), 0);
      chk({tag, "_final_tap"}, 32'(final_tap), 0);
      chk({tag, "_eye_width"}, 32'(eye_width), 0);
   endtask

   task automatic run_cal(input logic [7:0] mask, input logic gl, input logic cor, input logic dup);
      int fin, wid, base, k;
      logic [7:0] eff;
      pass_mask = mask;
      glitch_en = gl;
      corrupt   = cor;
      bad       = 4'($urandom_range(1, 15));
      eff = gl ? (mask & 8'hF7) : mask;
      ref_model(eff, fin, wid);
      base = load_cnt;
      @(negedge clk) start = 1'b1;
      @(posedge clk) #1;
      chk("busy_on", 32'(busy), 1);
      chk("vtc_off", 32'(en_vtc), 0);
      chk("done_clr", 32'(done), 0);
      @(negedge clk) start = 1'b0;
      k = 0;
      while (!load && k < 100) begin
         @(posedge clk) #1;
         k++;
      end
      chk("first_load_lat", 32'(k), 32'(VTC));
      if (dup) begin
         repeat (30) @(posedge clk);
         @(negedge clk) start = 1'b1;
         @(negedge clk) start = 1'b0;
         chk("busy_dup", 32'(busy), 1);
      end
      k = 0;
      while (!done && k < 2000) begin
         @(posedge clk) #1;
         k++;
      end
      chk("done_in_time", 32'(k < 2000), 1);
      chk("done", 32'(done), 1);
      chk("error", 32'(error), 32'(wid == 0 || cor));
      chk("final_tap", 32'(final_tap), 32'(fin));
      chk("eye_width", 32'(eye_width), 32'(wid));
      chk("en_vtc_on", 32'(en_vtc), 1);
      chk("busy_off", 32'(busy), 0);
      chk("load_count", 32'(load_cnt - base), 32'(NPTS + 1));
      chk("last_loaded", 32'(cur_tap), 32'(fin));
      chk("no_dbl_load", 32'(dbl_load), 0);
      repeat (3) @(posedge clk);
      #1 chk("done_hold", 32'(done), 1);
   endtask

   initial begin
      int base, k;
      repeat (3) @(posedge clk);
      #1 chk_reset("por");
      @(negedge clk) rst_n = 1'b1;

      run_cal(8'h3C, 1'b0, 1'b0, 1'b0);          // single eye 128..320

      // Async reset while sampling the second tap
      pass_mask = 8'h3C;
      glitch_en = 1'b0;
      corrupt   = 1'b0;
      base = load_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      k = 0;
      while (!((load_cnt - base) == 2 && since_load == 6) && k < 500) begin
         @(posedge clk) #1;
         k++;
      end
      chk("rst_reach_sample", 32'(k < 500), 1);
      #2 rst_n = 1'b0;
      #1 chk_reset("mid_rst");
      @(negedge clk) rst_n = 1'b1;

      run_cal(8'h73, 1'b0, 1'b0, 1'b0);          // {0,64} and {256,320,384}
      run_cal(8'h33, 1'b0, 1'b0, 1'b0);          // tied eyes
      run_cal(8'h00, 1'b0, 1'b0, 1'b0);          // no passing tap
      run_cal(8'h3C, 1'b1, 1'b0, 1'b0);          // one-cycle glitch at tap 192
      run_cal(8'h3C, 1'b0, 1'b1, 1'b0);          // corrupt readback
      run_cal(8'h3C, 1'b0, 1'b0, 1'b1);          // start while busy
      for (int i = 0; i < 8; i++)
         run_cal(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
